// File: rtl/mux_bus_pkg.sv
// Shared definitions for the mux bus arbiter slice.
//   N_REQ   number of bus requesters
//   SEL_W   width of the mux select / owner index
//   state_t arbiter FSM states
//   rr_next round-robin winner search starting after the previous owner
package mux_bus_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Search order last+1, last+2, last+3, last. The loop runs from the
  // lowest priority to the highest so the last hit is the winner.
  function automatic rr_pick_t rr_next(input logic [N_REQ-1:0] req,
                                       input logic [SEL_W-1:0] last);
    rr_pick_t         pick;
    logic [SEL_W-1:0] cand;
    pick = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_bus.sv
// WIDTH-wide 4:1 bus multiplexer built from two levels of mux2 cells.
//   mux2:     a/b data inputs, s select (1 picks b), y output
//   mux4_bus: d0..d3 data inputs, sel 2-bit select, y selected data
//             sel[0] chooses within each pair, sel[1] chooses the pair.
module mux2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

module mux4_bus #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] y01;
  logic [WIDTH-1:0] y23;

  mux2 #(.WIDTH(WIDTH)) u_m01 (.a(d0),  .b(d1),  .s(sel[0]), .y(y01));
  mux2 #(.WIDTH(WIDTH)) u_m23 (.a(d2),  .b(d3),  .s(sel[0]), .y(y23));
  mux2 #(.WIDTH(WIDTH)) u_mo  (.a(y01), .b(y23), .s(sel[1]), .y(y));
endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 mux bus.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester level request
//   data0..3   requester data
//   gnt        one-hot grant, zero when the bus has no owner (registered)
//   sel        mux select = current owner index, held while idle (registered)
//   bus_out    muxed data gated by bus_valid (combinational)
//   bus_valid  high while gnt is non-zero (registered)
// Tenure is bounded by MAX_HOLD cycles; every release is followed by one
// mandatory GAP cycle before the next IDLE arbitration.
module mux_bus_arbiter
  import mux_bus_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid
);

  localparam int unsigned           HOLD_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]     HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SEL_W-1:0]   last;
  rr_pick_t           pick;
  logic [WIDTH-1:0]   mux_out;

  always_comb begin
    pick = rr_next(req, last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      sel       <= '0;
      bus_valid <= 1'b0;
      hold_cnt  <= '0;
      last      <= 2'd3;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick.found) begin
            gnt           <= '0;
            gnt[pick.idx] <= 1'b1;
            sel           <= pick.idx;
            bus_valid     <= 1'b1;
            hold_cnt      <= HOLD_W'(1);
            state         <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!req[sel] || hold_cnt == HOLD_LIMIT) begin
            // sel is left untouched so the mux does not toggle while idle
            gnt       <= '0;
            bus_valid <= 1'b0;
            last      <= sel;
            hold_cnt  <= '0;
            state     <= ST_GAP;
          end else if (hold_cnt != HOLD_LIMIT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  mux4_bus #(.WIDTH(WIDTH)) u_mux (
    .d0  (data0),
    .d1  (data1),
    .d2  (data2),
    .d3  (data3),
    .sel (sel),
    .y   (mux_out)
  );

  assign bus_out = mux_out & {WIDTH{bus_valid}};

endmodule

// File: tb/tb_mux_bus_arbiter.sv
module tb_mux_bus_arbiter;

  localparam int W  = 16;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] d [4];
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] bus_out;
  logic         bus_valid;

  mux_bus_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data0     (d[0]),
    .data1     (d[1]),
    .data2     (d[2]),
    .data3     (d[3]),
    .gnt       (gnt),
    .sel       (sel),
    .bus_out   (bus_out),
    .bus_valid (bus_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner index (-1 = none), cycles of owned tenure,
  // remaining settle cycles after a release, previous owner, mux select.
  int m_owner, m_ten, m_cool, m_last, m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic int gnt_index(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ten = 0; m_cool = 0; m_last = 3; m_sel = 0;
  endtask

  // One clock edge: release, settle, or arbitrate.
  task automatic model_step(input logic [3:0] r);
    int w;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_ten == MH) begin
        m_last  = m_owner;
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_ten++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      w = rr_pick(r, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_ten   = 1;
        m_sel   = w;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0]   eg;
    logic [W-1:0] eb;
    eg = '0;
    eb = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eb = d[m_owner];
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("bus_valid", 32'(bus_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("bus_out", 32'(bus_out), 32'(eb));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (gnt != 4'b0000) chk("sel_matches_gnt", 32'(gnt[sel]), 32'd1);
    if (!bus_valid) chk("bus_out_gated", 32'(bus_out), 32'd0);
  endtask

  task automatic cycle();
    logic [3:0] r;
    r = req;
    @(posedge clk);
    if (rst_n) model_step(r);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int owners[$];
  int runs[$];
  int cur;

  task automatic track();
    if (gnt != 4'b0000) begin
      if (cur == 0) owners.push_back(gnt_index(gnt));
      cur++;
    end else if (cur > 0) begin
      runs.push_back(cur);
      cur = 0;
    end
  endtask

  initial begin
    d[0] = 16'hA5A5; d[1] = 16'h1111; d[2] = 16'h2222; d[3] = 16'h3333;
    req  = 4'b0000;

    // Reset state
    do_reset();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_bus_out", 32'(bus_out), 32'd0);

    // Single requester: grant on the next edge, bus carries data0
    req = 4'b0001;
    cycle();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_bus_out", 32'(bus_out), 32'hA5A5);

    // All requesting: rotation 0,1,2,3,0 with MAX_HOLD-long tenures
    do_reset();
    req = 4'b1111;
    owners.delete(); runs.delete(); cur = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      track();
    end
    chk("t2_tenures", (owners.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    if (owners.size() >= 5)
      for (int i = 0; i < 5; i++) chk("t2_owner", 32'(owners[i]), 32'(i % 4));
    chk("t2_runs", (runs.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (runs.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t2_run_len", 32'(runs[i]), 32'(MH));

    // Owner 2 drops early while requester 0 waits
    do_reset();
    req = 4'b0100;
    cycle();
    chk("t3_gnt2", 32'(gnt), 32'h4);
    req = 4'b0101;
    cycle();
    cycle();
    req = 4'b0001;
    cycle();
    chk("t3_release", 32'(gnt), 32'h0);
    cycle();
    chk("t3_gap", 32'(gnt), 32'h0);
    cycle();
    chk("t3_next", 32'(gnt), 32'h1);

    // Lone requester: forced release at MAX_HOLD then re-grant
    do_reset();
    req = 4'b0010;
    owners.delete(); runs.delete(); cur = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      track();
    end
    chk("t4_windows", (runs.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    if (runs.size() >= 2)
      for (int i = 0; i < 2; i++) begin
        chk("t4_run_len", 32'(runs[i]), 32'(MH));
        chk("t4_owner", 32'(owners[i]), 32'd1);
      end

    // Asynchronous reset in the middle of a tenure
    do_reset();
    req = 4'b0010;
    cycle();
    cycle();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_valid", 32'(bus_valid), 32'h0);
    chk("t5_bus_out", 32'(bus_out), 32'h0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000;
    cycle();
    chk("t5_regrant", 32'(gnt), 32'h8);

    // Random request traffic and data
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      for (int j = 0; j < 4; j++) d[j] = W'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
